// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants and helpers for the LED PWM driver and its prescaler.
package led_pwm_pkg;
  localparam int BITS_DEF = 4;
  function automatic int pmax_f(input int bits);
    return (1 << bits) - 1;
  endfunction
  localparam int PMAX = pmax_f(BITS_DEF);
  // Never returns less than 1 so a PRESCALE of 1 still yields a legal counter width.
  function automatic int clog2_f(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int nib_lo(input int i, input int bits);
    return i * bits;
  endfunction
endpackage

// File: rtl/pwm_tick.sv
// pwm_tick: free-running prescaler producing a one-cycle tick every PRESCALE clocks.
module pwm_tick import led_pwm_pkg::*; #(
  parameter int PRESCALE = 256
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int PW = clog2_f(PRESCALE);
  logic [PW-1:0] pcnt_q, pcnt_d;
  always_comb begin
    tick   = pcnt_q == PW'(PRESCALE - 1);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end
  always_ff @(posedge clk) pcnt_q <= reset ? '0 : pcnt_d;
endmodule

// File: rtl/led_pwm.sv
// led_pwm: per-LED 4-bit PWM with duty values shadowed at period boundaries so updates never glitch.
module led_pwm import led_pwm_pkg::*; #(
  parameter int WIDTH_D  = 32,
  parameter int N_LED    = 8,
  parameter int BITS     = BITS_DEF,
  parameter int PRESCALE = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH_D-1:0] data_in,
  output logic [N_LED-1:0]   led_out,
  output logic               frame
);
  localparam int PM = pmax_f(BITS);
  logic             tick, load, wrap, load_pending_q, frame_q;
  logic [BITS-1:0]  phase_q, phase_d;
  logic [BITS-1:0]  duty_q [N_LED];
  logic [BITS-1:0]  duty_d [N_LED];
  logic [N_LED-1:0] led_q, led_d;
  logic             unused_hi;
  pwm_tick #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  always_comb begin
    wrap    = tick & (phase_q == BITS'(PM - 1));
    load    = load_pending_q | wrap;
    phase_d = wrap ? '0 : (tick ? phase_q + 1'b1 : phase_q);
  end
  // Compare against the duty held before this edge; a fresh load shows up one cycle later at phase 0.
  for (genvar i = 0; i < N_LED; i++) begin : g_led
    localparam int LO = nib_lo(i, BITS);
    assign duty_d[i] = load ? data_in[LO +: BITS] : duty_q[i];
    assign led_d[i]  = phase_q < duty_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= '0;
      load_pending_q <= 1'b1;
      frame_q        <= 1'b0;
      led_q          <= '0;
      duty_q         <= '{default: '0};
    end else begin
      phase_q        <= phase_d;
      load_pending_q <= 1'b0;
      frame_q        <= load;
      led_q          <= led_d;
      duty_q         <= duty_d;
    end
  end
  assign unused_hi = ^data_in;
  assign led_out   = led_q;
  assign frame     = frame_q;
endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: self-checking bench comparing led_pwm against a cycle-count arithmetic model.
module tb_led_pwm;
  localparam int P   = 2;
  localparam int PER = 15 * P;
  logic        clk = 1'b0, reset = 1'b1, rst1 = 1'b1;
  logic [31:0] data_in = '0, data1 = '0;
  logic [7:0]  led_out, led1;
  logic        frame, frame1;
  int          n_chk = 0, n_fail = 0, c = 0;
  logic [31:0] duty_m = '0;
  logic [7:0]  exp_led = '0;
  logic        exp_frame = 1'b0;

  always #5 clk = ~clk;

  led_pwm #(.WIDTH_D(32), .N_LED(8), .BITS(4), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .led_out(led_out), .frame(frame));
  led_pwm #(.WIDTH_D(32), .N_LED(8), .BITS(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(rst1), .data_in(data1), .led_out(led1), .frame(frame1));

  // Model: c counts edges since reset release; step index of edge c is (c-1)/P mod 15,
  // loads happen at edge 1 and every edge where c is a multiple of the period.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      c = 0; duty_m = '0; exp_led = '0; exp_frame = 1'b0;
    end else begin
      c++;
      for (int i = 0; i < 8; i++) exp_led[i] = (((c - 1) / P) % 15) < int'(duty_m[i*4 +: 4]);
      exp_frame = (c == 1) || (c % PER == 0);
      if (exp_frame) duty_m = data_in;
    end
    #1;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3 * PER && !ok; k++) begin
      step();
      if (frame) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    reset = 1'b1; data_in = 32'hFFFF_FFFF;
    repeat (3) begin
      step();
      n_chk++;
      if (led_out !== 8'h00 || frame !== 1'b0) begin
        n_fail++; $display("FAIL reset_out: led_out=%h frame=%b expected 00/0", led_out, frame);
      end
      bad = 1'b0;
      for (int k = 0; k < 8; k++) if (dut.duty_q[k] !== 4'h0) bad = 1'b1;
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL reset_duty: duty nonzero during reset expected 0"); end
    end
    reset = 1'b0;
    step();
    n_chk++;
    if (led_out !== 8'h00 || frame !== 1'b1) begin
      n_fail++; $display("FAIL first_load: led_out=%h frame=%b expected 00/1", led_out, frame);
    end
    repeat (5) begin
      step();
      n_chk++;
      if (led_out !== 8'hFF || frame !== 1'b0) begin
        n_fail++; $display("FAIL after_load: led_out=%h frame=%b expected ff/0", led_out, frame);
      end
    end
  endtask

  task automatic test_mixed();
    bit ok;
    int cnt [8];
    int exp_cnt [8] = '{0, 0, 0, 2, 8, 16, 30, 0};
    data_in = 32'h0F84_1000;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL mixed_wait: frame=0 expected a pulse within bound"); end
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      for (int i = 0; i < 8; i++) cnt[i] += int'(led_out[i]);
      n_chk++;
      if (led_out !== exp_led) begin
        n_fail++; $display("FAIL mixed_cycle: led_out=%h expected %h", led_out, exp_led);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (cnt[i] != exp_cnt[i]) begin
        n_fail++; $display("FAIL mixed_count LED%0d: high=%0d expected %0d", i, cnt[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_glitch();
    bit ok;
    logic e;
    data_in = 32'h0000_0008;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL glitch_wait: frame=0 expected a pulse within bound"); end
    for (int k = 0; k < 2 * PER; k++) begin
      step();
      if (k == 6) data_in = 32'h0000_0002;
      e = (k < PER) ? (k < 16) : ((k - PER) < 4);
      n_chk++;
      if (led_out[0] !== e || led_out[7:1] !== 7'h0) begin
        n_fail++; $display("FAIL glitch k=%0d: led_out=%h expected LED0=%b", k, led_out, e);
      end
    end
  endtask

  task automatic test_frame();
    bit ok;
    int last_k = 0, nfr = 0;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL frame_wait: frame=0 expected a pulse within bound"); end
    for (int k = 1; k <= 5 * PER + 5; k++) begin
      step();
      if (frame) begin
        n_chk++;
        if (k - last_k != PER) begin
          n_fail++; $display("FAIL frame_gap: gap=%0d expected %0d", k - last_k, PER);
        end
        last_k = k; nfr++;
      end
    end
    n_chk++;
    if (nfr != 5) begin n_fail++; $display("FAIL frame_count: pulses=%0d expected 5", nfr); end
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    data_in = 32'hFFFF_FFFF;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL mid_wait: frame=0 expected a pulse within bound"); end
    repeat (15) step();
    n_chk++;
    if (led_out !== 8'hFF) begin n_fail++; $display("FAIL mid_pre: led_out=%h expected ff", led_out); end
    reset = 1'b1;
    repeat (3) begin
      step();
      n_chk++;
      if (led_out !== 8'h00 || frame !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset: led_out=%h frame=%b expected 00/0", led_out, frame);
      end
      bad = 1'b0;
      for (int k = 0; k < 8; k++) if (dut.duty_q[k] !== 4'h0) bad = 1'b1;
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL mid_duty: duty nonzero during reset expected 0"); end
    end
    reset = 1'b0;
    step();
    n_chk++;
    if (led_out !== 8'h00 || frame !== 1'b1) begin
      n_fail++; $display("FAIL mid_reload: led_out=%h frame=%b expected 00/1", led_out, frame);
    end
    step();
    n_chk++;
    if (led_out !== 8'hFF || frame !== 1'b0) begin
      n_fail++; $display("FAIL mid_on: led_out=%h frame=%b expected ff/0", led_out, frame);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 7) == 0) data_in = $urandom;
      reset = ($urandom_range(0, 299) == 0) || (reset && $urandom_range(0, 1) == 1);
      step();
      n_chk++;
      if (led_out !== exp_led || frame !== exp_frame) begin
        n_fail++;
        $display("FAIL random c=%0d: led_out=%h frame=%b expected %h/%b", c, led_out, frame, exp_led, exp_frame);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_prescale1();
    int highs = 0;
    logic el, ef;
    rst1 = 1'b1; data1 = 32'h0000_0001;
    repeat (2) step();
    rst1 = 1'b0;
    for (int c1 = 1; c1 <= 45; c1++) begin
      step();
      el = (c1 > 1) && ((c1 - 1) % 15 == 0);
      ef = (c1 == 1) || (c1 % 15 == 0);
      if (c1 >= 16) highs += int'(led1[0]);
      n_chk++;
      if (led1 !== {7'h0, el} || frame1 !== ef) begin
        n_fail++; $display("FAIL p1 c=%0d: led_out=%h frame=%b expected %h/%b", c1, led1, frame1, {7'h0, el}, ef);
      end
    end
    n_chk++;
    if (highs != 2) begin n_fail++; $display("FAIL p1_count: high=%0d expected 2", highs); end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_glitch();
    test_frame();
    test_reset_mid();
    test_random();
    test_prescale1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
